// File: rtl/psram_async_responder_if.sv
// Pin bundle between the byte-access memory controller and the PSRAM stand-in.
// master: controller side (drives control pins, address and db_in).
// slave : responder side (drives db_out / db_oe toward the controller).
interface psram_async_responder_if;
  localparam int unsigned ADR_W  = 23;
  localparam int unsigned DATA_W = 16;

  logic              MemOE;
  logic              MemWR;
  logic              RamCS;
  logic              RamUB;
  logic              RamLB;
  logic              MemAdv;
  logic              MemClk;
  logic              RamCRE;
  logic [ADR_W-1:0]  MemAdr;
  logic [DATA_W-1:0] db_in;
  logic [DATA_W-1:0] db_out;
  logic              db_oe;

  modport master (
    output MemOE, MemWR, RamCS, RamUB, RamLB, MemAdv, MemClk, RamCRE, MemAdr, db_in,
    input  db_out, db_oe
  );

  modport slave (
    input  MemOE, MemWR, RamCS, RamUB, RamLB, MemAdv, MemClk, RamCRE, MemAdr, db_in,
    output db_out, db_oe
  );
endinterface

// File: rtl/psram_async_responder.sv
// Clocked stand-in for an asynchronous 16-bit PSRAM, backed by an on-chip word
// array. Samples the controller pins every clock, answers reads after a
// programmable latency and commits byte-lane writes when the write cycle ends.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   bus          psram_async_responder_if.slave (control pins, MemAdr, db_in,
//                db_out, db_oe)
//   rd_count     completed read cycles (saturating)
//   wr_count     committed write cycles (saturating)
//   err          sticky protocol error        (PSRAM_PROTOCOL_CHECK_EN)
//   err_code     first protocol error cause   (PSRAM_PROTOCOL_CHECK_EN)
//
// Optional feature: define PSRAM_PROTOCOL_CHECK_EN to build the protocol
// checker; otherwise err/err_code are tied to 0.
module psram_async_responder #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  psram_async_responder_if.slave bus,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count,
  output logic                 err,
  output logic [2:0]           err_code
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LAT_W  = 3;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] rd_adr_q;
  logic [ADDR_W-1:0] wr_adr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_ub_q, wr_lb_q;
  logic [DATA_W-1:0] db_out_q;
  logic              db_oe_q;

  logic              active_c;
  logic              rd_end_c;
  logic [ADDR_W-1:0] adr_c;
  logic              rd_start_c;
  logic              rd_load_c;
  logic              rd_stop_c;
  logic              rd_done_c;
  logic              wr_cap_c;
  logic              wr_commit_c;

  // Upper address pins alias; mode pins only matter to the checker.
  logic unused_pins;
  assign unused_pins = ^{bus.MemAdv, bus.MemClk, bus.RamCRE, bus.MemAdr[22:ADDR_W]};

  // A cycle is live only with chip select and at least one byte lane enabled.
  assign active_c = ~bus.RamCS & (~bus.RamUB | ~bus.RamLB);
  assign rd_end_c = bus.RamCS | bus.MemOE | ~active_c;
  assign adr_c    = bus.MemAdr[ADDR_W-1:0];

  assign bus.db_out = db_out_q;
  assign bus.db_oe  = db_oe_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    rd_start_c  = 1'b0;
    rd_load_c   = 1'b0;
    rd_stop_c   = 1'b0;
    rd_done_c   = 1'b0;
    wr_cap_c    = 1'b0;
    wr_commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        // WE dominates when OE and WE are both asserted.
        if (active_c && !bus.MemWR) begin
          state_d  = WR_ACTIVE;
          wr_cap_c = 1'b1;
        end else if (active_c && !bus.MemOE) begin
          state_d    = RD_WAIT;
          rd_start_c = 1'b1;
          lat_d      = LAT_W'(1);
        end
      end
      RD_WAIT, RD_DRIVE: begin
        if (rd_end_c) begin
          state_d   = IDLE;
          rd_stop_c = 1'b1;
          rd_done_c = (state_q == RD_DRIVE);
        end else if (adr_c != rd_adr_q) begin
          // New address mid-read: release the bus and restart the latency.
          state_d    = RD_WAIT;
          rd_start_c = 1'b1;
          lat_d      = LAT_W'(1);
        end else if (state_q == RD_WAIT) begin
          if (lat_q == LAT_W'(READ_LAT)) begin
            state_d   = RD_DRIVE;
            rd_load_c = 1'b1;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end else begin
          rd_load_c = 1'b1;
        end
      end
      WR_ACTIVE: begin
        // Commit uses the values captured before the deasserting edge.
        if (bus.RamCS || bus.MemWR) begin
          state_d     = IDLE;
          wr_commit_c = 1'b1;
        end else begin
          wr_cap_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read/write datapath and transaction counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_adr_q  <= '0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      wr_ub_q   <= 1'b1;
      wr_lb_q   <= 1'b1;
      db_out_q  <= '0;
      db_oe_q   <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      if (rd_start_c) begin
        rd_adr_q <= adr_c;
        db_oe_q  <= 1'b0;
      end
      if (rd_load_c) begin
        db_out_q <= mem[rd_adr_q];
        db_oe_q  <= 1'b1;
      end
      if (rd_stop_c) begin
        db_oe_q <= 1'b0;
      end
      if (rd_done_c && (rd_count != '1)) begin
        rd_count <= rd_count + CNT_W'(1);
      end
      if (wr_cap_c) begin
        wr_adr_q  <= adr_c;
        wr_data_q <= bus.db_in;
        wr_ub_q   <= bus.RamUB;
        wr_lb_q   <= bus.RamLB;
      end
      if (wr_commit_c && (wr_count != '1)) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  // Word array: byte-lane write, contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_commit_c) begin
      if (!wr_ub_q) begin
        mem[wr_adr_q][15:8] <= wr_data_q[15:8];
      end
      if (!wr_lb_q) begin
        mem[wr_adr_q][7:0] <= wr_data_q[7:0];
      end
    end
  end

`ifdef PSRAM_PROTOCOL_CHECK_EN
  logic [22:0] chk_adr_q;
  logic        chk_ub_q, chk_lb_q;
  logic [2:0]  cause_c;

  // Highest-priority cause seen this clock while chip select is low.
  always_comb begin
    cause_c = 3'd0;
    if (!bus.RamCS) begin
      if (bus.MemAdv || bus.MemClk || bus.RamCRE) begin
        cause_c = 3'd1;
      end else if ((state_q == WR_ACTIVE) && (bus.MemAdr != chk_adr_q)) begin
        cause_c = 3'd2;
      end else if (!bus.MemOE && !bus.MemWR) begin
        cause_c = 3'd3;
      end else if ((state_q == WR_ACTIVE) &&
                   ((bus.RamUB != chk_ub_q) || (bus.RamLB != chk_lb_q))) begin
        cause_c = 3'd4;
      end
    end
  end

  // Sticky error; only the first cause is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_adr_q <= '0;
      chk_ub_q  <= 1'b1;
      chk_lb_q  <= 1'b1;
      err       <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      chk_adr_q <= bus.MemAdr;
      chk_ub_q  <= bus.RamUB;
      chk_lb_q  <= bus.RamLB;
      if (!err && (cause_c != 3'd0)) begin
        err      <= 1'b1;
        err_code <= cause_c;
      end
    end
  end
`else
  assign err      = 1'b0;
  assign err_code = 3'd0;
`endif

endmodule

// File: tb/tb_psram_async_responder.sv
// Scoreboard bench for psram_async_responder: read stimulus pushes the
// hand-computed word into a queue, a forked monitor pops it on each rising
// db_oe and compares db_out. A second instance with narrow counters covers
// counter saturation.
module tb_psram_async_responder;
  localparam int unsigned RL    = 2;
  localparam int unsigned SAT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  psram_async_responder_if bus();
  psram_async_responder_if sbus();

  logic [15:0]      rd_count, wr_count;
  logic             err;
  logic [2:0]       err_code;
  logic [SAT_W-1:0] s_rd_count, s_wr_count;
  logic             s_err;
  logic [2:0]       s_err_code;

  psram_async_responder #(.ADDR_W(10), .READ_LAT(RL), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .err      (err),
    .err_code (err_code)
  );

  psram_async_responder #(.ADDR_W(10), .READ_LAT(1), .CNT_W(SAT_W)) sdut (
    .clk      (clk),
    .reset    (reset),
    .bus      (sbus),
    .rd_count (s_rd_count),
    .wr_count (s_wr_count),
    .err      (s_err),
    .err_code (s_err_code)
  );

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pins();
    bus.RamCS = 1'b1; bus.MemOE = 1'b1; bus.MemWR = 1'b1;
    bus.RamUB = 1'b1; bus.RamLB = 1'b1;
    bus.MemAdv = 1'b0; bus.MemClk = 1'b0; bus.RamCRE = 1'b0;
  endtask

  // Write cycle: CS/WE low for 'hold' sampled clocks, then deassert.
  task automatic do_write(input logic [22:0] a, input logic [15:0] d, input logic ub,
                          input logic lb, input logic oe, input int hold);
    bus.MemAdr = a; bus.db_in = d; bus.RamUB = ub; bus.RamLB = lb;
    bus.MemOE = oe; bus.MemWR = 1'b0; bus.RamCS = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("wr_no_drive", 32'(bus.db_oe), 32'd0);
    end
    idle_pins();
    step();
    chk("wr_no_drive", 32'(bus.db_oe), 32'd0);
  endtask

  // Starts a read, checks the drive latency and leaves the bus driven.
  task automatic read_open(input logic [22:0] a, input logic [15:0] expv);
    int lat;
    lat = 0;
    exp_q.push_back(expv);
    bus.MemAdr = a; bus.RamUB = 1'b0; bus.RamLB = 1'b0;
    bus.MemWR = 1'b1; bus.MemOE = 1'b0; bus.RamCS = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step();
      if (bus.db_oe) lat = i;
    end
    chk("rd_latency", 32'(lat), 32'(RL + 1));
  endtask

  task automatic read_close();
    idle_pins();
    step();
    chk("rd_end_release", 32'(bus.db_oe), 32'd0);
  endtask

  task automatic do_read(input logic [22:0] a, input logic [15:0] expv, input int hold);
    read_open(a, expv);
    repeat (hold) step();
    chk("rd_hold_drive", 32'(bus.db_oe), 32'd1);
    read_close();
  endtask

  task automatic sat_write(input logic [22:0] a);
    sbus.MemAdr = a; sbus.db_in = 16'(a); sbus.RamUB = 1'b0; sbus.RamLB = 1'b0;
    sbus.MemWR = 1'b0; sbus.RamCS = 1'b0;
    step();
    sbus.RamCS = 1'b1; sbus.MemWR = 1'b1; sbus.RamUB = 1'b1; sbus.RamLB = 1'b1;
    step();
  endtask

  // Scoreboard monitor: one expected word per rising edge of db_oe.
  task automatic monitor();
    logic prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.db_oe && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected_drive actual=%0h required=no_drive", bus.db_out);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(bus.db_out), 32'(e));
        end
      end
      prev = bus.db_oe;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    fork
      monitor();
    join_none

    idle_pins();
    bus.MemAdr = '0; bus.db_in = '0;
    sbus.RamCS = 1'b1; sbus.MemOE = 1'b1; sbus.MemWR = 1'b1;
    sbus.RamUB = 1'b1; sbus.RamLB = 1'b1;
    sbus.MemAdv = 1'b0; sbus.MemClk = 1'b0; sbus.RamCRE = 1'b0;
    sbus.MemAdr = '0; sbus.db_in = '0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();

    chk("reset_db_oe", 32'(bus.db_oe), 32'd0);
    chk("reset_db_out", 32'(bus.db_out), 32'd0);
    chk("reset_rd_count", 32'(rd_count), 32'd0);
    chk("reset_wr_count", 32'(wr_count), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_err_code", 32'(err_code), 32'd0);

    // Upper-lane write preserves the lower lane.
    do_write(23'h000005, 16'h1234, 1'b0, 1'b0, 1'b1, 2);
    do_write(23'h000005, 16'hAB00, 1'b0, 1'b1, 1'b1, 3);
    do_read(23'h000005, 16'hAB34, 2);
    chk("t1_rd_count", 32'(rd_count), 32'd1);
    chk("t1_wr_count", 32'(wr_count), 32'd2);

    // Separate lane writes on the top word, then address aliasing.
    do_write(23'h0003FF, 16'h0012, 1'b1, 1'b0, 1'b1, 1);
    do_write(23'h0003FF, 16'h3400, 1'b0, 1'b1, 1'b1, 1);
    do_read(23'h0003FF, 16'h3412, 1);
    do_write(23'h000400, 16'hBEEF, 1'b0, 1'b0, 1'b1, 2);
    do_read(23'h000000, 16'hBEEF, 1);
    chk("t2_rd_count", 32'(rd_count), 32'd3);
    chk("t2_wr_count", 32'(wr_count), 32'd5);

    // Both byte enables high: not a cycle.
    bus.MemAdr = 23'h000005; bus.MemOE = 1'b0; bus.RamCS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("inactive_no_drive", 32'(bus.db_oe), 32'd0);
    end
    idle_pins();
    step();
    chk("inactive_rd_count", 32'(rd_count), 32'd3);

    // OE and WE both low: write wins.
    do_write(23'h000020, 16'h5555, 1'b0, 1'b0, 1'b0, 3);
    chk("both_low_wr_count", 32'(wr_count), 32'd6);
`ifdef PSRAM_PROTOCOL_CHECK_EN
    chk("both_low_err", 32'(err), 32'd1);
    chk("both_low_err_code", 32'(err_code), 32'd3);
`else
    chk("both_low_err", 32'(err), 32'd0);
    chk("both_low_err_code", 32'(err_code), 32'd0);
`endif
    do_read(23'h000020, 16'h5555, 1);

    // Address change during a driven read.
    do_write(23'h000010, 16'h1010, 1'b0, 1'b0, 1'b1, 1);
    do_write(23'h000011, 16'h2011, 1'b0, 1'b0, 1'b1, 1);
    read_open(23'h000010, 16'h1010);
    step();
    exp_q.push_back(16'h2011);
    bus.MemAdr = 23'h000011;
    step();
    chk("addr_change_release", 32'(bus.db_oe), 32'd0);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step();
      if (bus.db_oe) lat = i;
    end
    chk("addr_change_latency", 32'(lat), 32'(RL));
    read_close();
    chk("t5_rd_count", 32'(rd_count), 32'd5);
    chk("t5_wr_count", 32'(wr_count), 32'd8);

    // Reset in the middle of a write aborts it.
    do_write(23'h000030, 16'h0F0F, 1'b0, 1'b0, 1'b1, 1);
    chk("t6_wr_count", 32'(wr_count), 32'd9);
    bus.MemAdr = 23'h000030; bus.db_in = 16'hAAAA; bus.RamUB = 1'b0; bus.RamLB = 1'b0;
    bus.MemWR = 1'b0; bus.RamCS = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_pins();
    step();
    chk("abort_wr_count", 32'(wr_count), 32'd0);
    chk("abort_rd_count", 32'(rd_count), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_err_code", 32'(err_code), 32'd0);
    do_read(23'h000030, 16'h0F0F, 1);
    chk("abort_read_count", 32'(rd_count), 32'd1);

    // Counter saturation on the narrow-counter instance.
    for (int i = 0; i < 254; i++) sat_write(23'(i));
    chk("sat_wr_count_fe", 32'(s_wr_count), 32'hFE);
    sat_write(23'd254);
    chk("sat_wr_count_ff", 32'(s_wr_count), 32'hFF);
    sat_write(23'd255);
    chk("sat_wr_count_hold", 32'(s_wr_count), 32'hFF);
    chk("sat_rd_count", 32'(s_rd_count), 32'd0);
    chk("sat_err", 32'({s_err, s_err_code}), 32'd0);

    repeat (3) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
